// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with a per-register write-pending scoreboard.
// Decode reads two operands and their in-use flags combinationally; writeback
// retires results and decrements the pending count of the destination.
// Optional feature: define RF_BYPASS_EN for write-through forwarding on both read ports.
module reg_file_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcReg1,
  input  logic [ADDR_W-1:0] srcReg2,
  input  logic [ADDR_W-1:0] nextDestReg,
  input  logic              issueEn,
  input  logic              wbEn,
  input  logic [ADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0] wbData,
  input  logic              flush,
  output logic [DATA_W-1:0] srcRegVal1,
  output logic [DATA_W-1:0] srcRegVal2,
  output logic              inuse1,
  output logic              inuse2,
  output logic              scbErr
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  // Decode the issue and writeback indices into one-hot per-register requests
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = issueEn && (nextDestReg == ADDR_W'(r));
      dec_vec[r] = wbEn && (wbReg == ADDR_W'(r));
    end
  end

  // Operand read path; with forwarding a same-cycle retire is visible immediately
  always_comb begin
    srcRegVal1 = regs[srcReg1];
    srcRegVal2 = regs[srcReg2];
    inuse1     = (cnt[srcReg1] != '0);
    inuse2     = (cnt[srcReg2] != '0);
`ifdef RF_BYPASS_EN
    // The flag reports the count that remains once this retire has landed
    if (wbEn && (wbReg == srcReg1) && !rst) begin
      srcRegVal1 = wbData;
      inuse1     = (cnt[srcReg1] > CNT_ONE);
    end
    if (wbEn && (wbReg == srcReg2) && !rst) begin
      srcRegVal2 = wbData;
      inuse2     = (cnt[srcReg2] > CNT_ONE);
    end
`else
    // Without forwarding decode sees the retired value one cycle later
`endif
  end

  // Register array: writeback lands regardless of counter state or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wbEn) begin
      regs[wbReg] <= wbData;
    end
  end

  // Pending counters and sticky error; flush discards all writers including a same-cycle issue
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      scbErr <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (flush) begin
          cnt[r] <= '0;
        end else if (inc_vec[r] && !dec_vec[r]) begin
          if (cnt[r] == CNT_MAX) begin
            scbErr <= 1'b1;
          end else begin
            cnt[r] <= cnt[r] + CNT_ONE;
          end
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (cnt[r] == '0) begin
            scbErr <= 1'b1;
          end else begin
            cnt[r] <= cnt[r] - CNT_ONE;
          end
        end
      end
    end
  end

endmodule
